// File: rtl/antares_add_arbiter_pkg.sv
// Shared types and widths for the antares add/subtract arbiter.
// State encoding is fixed so checkers can decode the debug state output directly.
package antares_add_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int OP_W   = 32;
  localparam int WIDE_W = 64;

endpackage

// File: rtl/antares_addc.sv
// 32-bit combinational adder with carry in and carry out.
// This is the single datapath shared by all requesters.
module antares_addc
  import antares_add_arbiter_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  logic            cin,
  output logic [OP_W-1:0] sum,
  output logic            cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{OP_W{1'b0}}, cin};

endmodule

// File: rtl/antares_add_arbiter.sv
// Round-robin arbiter time-sharing one 32-bit adder among N_REQ requesters.
// 64-bit operations take two passes, low word first, chaining the carry.
module antares_add_arbiter
  import antares_add_arbiter_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*WIDE_W-1:0] req_a,
  input  logic [N_REQ*WIDE_W-1:0] req_b,
  input  logic [N_REQ-1:0]        req_wide,
  input  logic [N_REQ-1:0]        req_sub,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [WIDE_W-1:0]       rsp_data,
  output logic                    rsp_carry,
  output logic [1:0]              state_dbg,
  output logic [ID_W-1:0]         rr_ptr_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and ready never depends on rsp_ready.

  state_t              state, state_next;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     grant;
  logic [ID_W-1:0]     grant_inc;
  logic                accept;
  logic [WIDE_W-1:0]   op_a, op_b;
  logic                op_wide, op_sub;
  logic                c_lo;

  logic                hi_pass;
  logic [OP_W-1:0]     add_a, add_b_raw, add_b;
  logic                add_cin;
  logic [OP_W-1:0]     add_sum;
  logic                add_cout;

  // First set valid bit at or above ptr, wrapping; returns ptr when none set.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                              input logic [ID_W-1:0]  ptr);
    logic            found;
    logic [ID_W-1:0] pick;
    found = 1'b0;
    pick  = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      int idx;
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && v[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign grant     = rr_pick(req_valid, rr_ptr);
  assign grant_inc = (int'(grant) == N_REQ - 1) ? '0 : grant + 1'b1;
  assign accept    = (state == ST_IDLE) && (|req_valid);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_LO;
      ST_LO:   state_next = op_wide ? ST_HI : ST_RESP;
      ST_HI:   state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Subtract is A + ~B + 1 on the low pass; the high pass carries in c_lo.
  assign hi_pass   = (state == ST_HI);
  assign add_a     = hi_pass ? op_a[WIDE_W-1:OP_W] : op_a[OP_W-1:0];
  assign add_b_raw = hi_pass ? op_b[WIDE_W-1:OP_W] : op_b[OP_W-1:0];
  assign add_b     = op_sub ? ~add_b_raw : add_b_raw;
  assign add_cin   = hi_pass ? c_lo : op_sub;

  antares_addc u_addc (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_carry <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_wide   <= 1'b0;
      op_sub    <= 1'b0;
      c_lo      <= 1'b0;
    end else begin
      state     <= state_next;
      rsp_valid <= (state_next == ST_RESP);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_a    <= req_a[int'(grant)*WIDE_W +: WIDE_W];
            op_b    <= req_b[int'(grant)*WIDE_W +: WIDE_W];
            op_wide <= req_wide[grant];
            op_sub  <= req_sub[grant];
            rsp_id  <= grant;
            rr_ptr  <= grant_inc;
            if (!req_wide[grant]) rsp_data[WIDE_W-1:OP_W] <= '0;
          end
        end
        ST_LO: begin
          rsp_data[OP_W-1:0] <= add_sum;
          c_lo               <= add_cout;
          if (!op_wide) rsp_carry <= add_cout;
        end
        ST_HI: begin
          rsp_data[WIDE_W-1:OP_W] <= add_sum;
          rsp_carry               <= add_cout;
        end
        default: ;
      endcase
    end
  end

  assign state_dbg  = state;
  assign rr_ptr_dbg = rr_ptr;

endmodule

// File: tb/tb_antares_add_arbiter.sv
// Directed bench for antares_add_arbiter: an arithmetic model feeds an expected
// queue at each accept, and responses are popped and compared on handshake.
module tb_antares_add_arbiter;

  localparam int N    = 2;
  localparam int ID_W = 1;
  localparam int W    = ID_W + 1 + 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready, req_wide, req_sub;
  logic [N*64-1:0]   req_a, req_b;
  logic              rsp_valid, rsp_ready, rsp_carry;
  logic [ID_W-1:0]   rsp_id, rr_ptr_dbg;
  logic [63:0]       rsp_data;
  logic [1:0]        state_dbg;

  logic [W-1:0]      exp_q[$];
  int                tests = 0;
  int                fails = 0;

  antares_add_arbiter #(.N_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_wide   (req_wide),
    .req_sub    (req_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_carry  (rsp_carry),
    .state_dbg  (state_dbg),
    .rr_ptr_dbg (rr_ptr_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [63:0] a, input logic [63:0] b,
                         input logic wide, input logic sub);
    req_a[id*64 +: 64] = a;
    req_b[id*64 +: 64] = b;
    req_wide[id]       = wide;
    req_sub[id]        = sub;
    req_valid[id]      = 1'b1;
  endtask

  // Independent reference: full-width sum with the subtract expressed as A + ~B + 1.
  task automatic push_model(input int id);
    logic [63:0] a, b, d;
    logic [64:0] s;
    logic [32:0] t;
    logic        c;
    a = req_a[id*64 +: 64];
    b = req_b[id*64 +: 64];
    if (req_wide[id]) begin
      s = {1'b0, a} + {1'b0, (req_sub[id] ? ~b : b)} + 65'(req_sub[id]);
      d = s[63:0];
      c = s[64];
    end else begin
      t = {1'b0, a[31:0]} + {1'b0, (req_sub[id] ? ~b[31:0] : b[31:0])} + 33'(req_sub[id]);
      d = {32'h0, t[31:0]};
      c = t[32];
    end
    exp_q.push_back({ID_W'(id), c, d});
  endtask

  // Expect requester id to be granted this cycle; returns just after the accept edge.
  task automatic accept(input int id);
    #1;
    check("req_ready_grant", 64'(req_ready), 64'(1 << id));
    push_model(id);
    tick();
  endtask

  task automatic wait_valid(input int exp_lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("rsp_latency", 64'(n), 64'(exp_lat));
  endtask

  task automatic compare_front();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 64'(0), 64'(1));
    end else begin
      e = exp_q.pop_front();
      check("rsp_id", 64'(rsp_id), 64'(e[W-1 -: ID_W]));
      check("rsp_carry", 64'(rsp_carry), 64'(e[64]));
      check("rsp_data", rsp_data, e[63:0]);
    end
  endtask

  task automatic collect(input int exp_lat);
    wait_valid(exp_lat);
    compare_front();
    tick();
    check("rsp_valid_drop", 64'(rsp_valid), 64'(0));
  endtask

  initial begin
    logic [W-1:0] e;
    rst       = 1'b1;
    req_valid = '0;
    req_wide  = '0;
    req_sub   = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_data", rsp_data, 64'(0));
    check("reset_rsp_id", 64'(rsp_id), 64'(0));
    check("reset_rsp_carry", 64'(rsp_carry), 64'(0));
    check("reset_req_ready", 64'(req_ready), 64'(0));
    check("reset_rr_ptr", 64'(rr_ptr_dbg), 64'(0));
    check("reset_state", 64'(state_dbg), 64'(0));
    rst = 1'b0;
    tick();

    // Narrow add wrapping to zero with carry out.
    set_req(0, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0);
    accept(0);
    req_valid[0] = 1'b0;
    collect(1);

    // Wide subtract borrowing across the word boundary.
    set_req(0, 64'h1_0000_0000, 64'h1, 1'b1, 1'b1);
    accept(0);
    req_valid[0] = 1'b0;
    collect(2);

    // Narrow subtract with borrow; upper word must be cleared.
    set_req(0, 64'h0, 64'h1, 1'b0, 1'b1);
    accept(0);
    req_valid[0] = 1'b0;
    collect(1);
    check("borrow_upper_clear", rsp_data, 64'h0000_0000_FFFF_FFFF);

    // Random single-requester operations.
    for (int k = 0; k < 8; k++) begin
      int  id;
      logic w;
      id = int'($urandom_range(0, N - 1));
      w  = 1'($urandom_range(0, 1));
      set_req(id, {$urandom, $urandom}, {$urandom, $urandom}, w, 1'($urandom_range(0, 1)));
      accept(id);
      req_valid[id] = 1'b0;
      collect(w ? 2 : 1);
    end

    // Backpressure with req1 waiting behind a stalled response.
    set_req(0, 64'h1234_5678, 64'h0000_1111, 1'b0, 1'b0);
    accept(0);
    req_valid[0] = 1'b0;
    set_req(1, 64'h0000_0001_FFFF_FFFF, 64'h1, 1'b1, 1'b0);
    rsp_ready = 1'b0;
    wait_valid(1);
    e = (exp_q.size() != 0) ? exp_q[0] : '0;
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      check("bp_rsp_data", rsp_data, e[63:0]);
      check("bp_req_ready", 64'(req_ready), 64'(0));
      tick();
    end
    rsp_ready = 1'b1;
    compare_front();
    tick();
    check("bp_rsp_valid_drop", 64'(rsp_valid), 64'(0));
    accept(1);
    req_valid[1] = 1'b0;
    collect(2);

    // Reset during the high pass of a wide operation.
    set_req(0, 64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
    accept(0);
    req_valid[0] = 1'b0;
    check("mid_state_lo", 64'(state_dbg), 64'(1));
    tick();
    check("mid_state_hi", 64'(state_dbg), 64'(2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(exp_q.pop_back());
    check("mid_rst_state", 64'(state_dbg), 64'(0));
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("mid_rst_rsp_data", rsp_data, 64'(0));
    check("mid_rst_rsp_id", 64'(rsp_id), 64'(0));
    check("mid_rst_rsp_carry", 64'(rsp_carry), 64'(0));
    check("mid_rst_rr_ptr", 64'(rr_ptr_dbg), 64'(0));
    check("mid_rst_req_ready", 64'(req_ready), 64'(0));
    for (int k = 0; k < 4; k++) begin
      tick();
      check("dropped_no_rsp", 64'(rsp_valid), 64'(0));
    end
    set_req(1, 64'h10, 64'h20, 1'b0, 1'b1);
    accept(1);
    req_valid[1] = 1'b0;
    check("post_rst_rr_ptr", 64'(rr_ptr_dbg), 64'(0));
    collect(1);

    // Fairness: both requesters held valid, grants must alternate 0,1,0,1.
    set_req(0, {32'h0, $urandom}, {32'h0, $urandom}, 1'b0, 1'b0);
    set_req(1, {32'h0, $urandom}, {32'h0, $urandom}, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      accept(k % 2);
      collect(1);
    end
    check("fair_rr_ptr", 64'(rr_ptr_dbg), 64'(0));
    req_valid = '0;
    tick();

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
